syn_vga_fb_rdr: RTL and testbench
=================================

# syn_vga_fb_rdr

Frame-buffer reader for the display path. The GPU pixel gateway writes rendered pixels into SRAM; this block is the read side of that same frame buffer. It fetches packed pixel words from SRAM through a request/grant read port, buffers them in a prefetch FIFO, and streams one 8-bit pixel per handshake to the VGA timing/output stage. It also counts underflows so firmware can detect bandwidth starvation by the GPU writer.

## Interface

- FIFO_DEPTH, 16, prefetch FIFO depth in 16-bit words (power of 2, 4..64)
- FRAME_WORDS, 153600, SRAM words per frame (640x480 at 8 bpp, 2 pixels/word)
- ADDR_W, 18, SRAM word address width
- clk_ir  in  1  system clock; single clock domain
- rst_sync  in  1  reset, synchronous, active-high
- fb_en  in  1  fetch/stream enable; level
- frame_start  in  1  one-cycle pulse at the start of each frame (from VGA timing)
- fb_base  in  ADDR_W  frame base word address; sampled on frame_start
- sram_rd_req  out  1  read request; held until granted
- sram_rd_addr  out  ADDR_W  read word address; stable while sram_rd_req=1 and not granted
- sram_rd_gnt  in  1  request accepted this cycle
- sram_rd_valid  in  1  read data return strobe; returns are in order
- sram_rd_data  in  16  read data; [7:0] is the even pixel, [15:8] the odd pixel
- pxl_vld  out  1  pixel available
- pxl_data  out  8  pixel value
- pxl_rdy  in  1  display consumes pixel when pxl_vld && pxl_rdy
- underflow_cnt  out  16  count of starved cycles this frame; saturating

## Operation

- State: IDLE, FETCH, DONE.
  - IDLE → FETCH on frame_start && fb_en.
  - FETCH → DONE when word_cnt reaches FRAME_WORDS grants.
  - Any state → FETCH on frame_start && fb_en; → IDLE on frame_start && !fb_en.
  - fb_en low in FETCH freezes new requests only. The state does not change.
- On frame_start:
  - base_q ← fb_base; word_cnt ← 0.
  - FIFO flushed; byte-select ← 0; underflow_cnt ← 0.
  - drop_cnt ← current inflight count, plus 1 if sram_rd_gnt is high the same cycle.
- sram_rd_addr = (base_q + word_cnt) mod 2^ADDR_W. Wraps silently.
- Credit rule: sram_rd_req = FETCH && fb_en && (fifo_occ + inflight < FIFO_DEPTH).
  - inflight = granted, not yet returned.
  - The FIFO therefore never overflows.
- On gnt: word_cnt++ and inflight++.
- On rd_valid: inflight--.
  - If drop_cnt > 0: discard the data and drop_cnt--.
  - Otherwise: push the data into the FIFO.
- Unpacker:
  - pxl_data = byte-select ? head[15:8] : head[7:0].
  - pxl_vld = FIFO non-empty.
  - On handshake: toggle byte-select. Pop the FIFO when byte-select was 1.
- Underflow: increments once per cycle when all of these hold: FETCH or DONE, fb_en, pxl_rdy, !pxl_vld, and frame not fully consumed (pixels popped < 2*FRAME_WORDS). Saturates at 0xFFFF.
- sram_rd_gnt without sram_rd_req is ignored.
- rd_valid with inflight = 0 is ignored; no push.

## Timing

- Reset values:
  - sram_rd_req=0, sram_rd_addr=0, pxl_vld=0, pxl_data=0, underflow_cnt=0.
  - State IDLE; all counters 0; FIFO empty.
- Reset mid-frame aborts immediately. Returns arriving after reset are ignored because inflight=0.
- frame_start registered: the first sram_rd_req is asserted the cycle after the frame_start pulse.
- Address advances the cycle after gnt. Back-to-back grants give one word per cycle.
- Read latency is any value ≥ 1 cycle; the block is order-dependent only.
- FIFO write to pxl_vld: 1 cycle. pxl_data and pxl_vld are registered outputs of the FIFO head.
- Full throughput: 2 pixels per word, so requests need only 50% grant duty cycle.
- Simultaneous push and pop in one cycle is supported. Occupancy is unchanged.
- Simultaneous frame_start and rd_valid: the return is dropped and counted against the new drop_cnt.

## Test plan

- Basic stream:
  - Stimulus: fb_base=0x100, FRAME_WORDS=4, SRAM returns word k as {2k+1, 2k} with 2-cycle latency, gnt always high, pxl_rdy=1.
  - Required: addresses 0x100..0x103 requested; pxl_data sequence 0..7; sram_rd_req low after 4 grants; underflow_cnt=0.
- Backpressure:
  - Stimulus: pxl_rdy=0 for 100 cycles.
  - Required: at most FIFO_DEPTH=16 grants issued; no pixel lost or duplicated after pxl_rdy=1.
- Address wrap:
  - Stimulus: fb_base=0x3FFFE, FRAME_WORDS=4.
  - Required: addresses 0x3FFFE, 0x3FFFF, 0x00000, 0x00001.
- Mid-frame restart:
  - Stimulus: frame_start issued with 3 reads inflight, coincident with a fourth gnt; new fb_base=0x200.
  - Required: 4 stale returns discarded; first new pixel is the low byte of word 0x200.
- Starvation:
  - Stimulus: gnt held low for 10 cycles with FIFO empty and pxl_rdy=1.
  - Required: underflow_cnt=10; cleared to 0 on next frame_start; saturates at 0xFFFF in a long-stall test.
- Synchronous reset:
  - Stimulus: rst_sync asserted mid-FETCH with data inflight.
  - Required: next cycle all outputs at reset values; late rd_valid pulses produce no pxl_vld.

Source files
------------

// File: rtl/syn_vga_fb_rdr.sv
`default_nettype none
// ============================================================================
//  Module   : syn_vga_fb_rdr
//  Purpose  : Frame-buffer read side. Fetches packed 2-pixel words from SRAM
//             under a credit limit, prefetches into a FIFO, streams bytes out.
//  Revision : 1.0  initial release
// ============================================================================
module syn_vga_fb_rdr #(
    parameter int FIFO_DEPTH  = 16,
    parameter int FRAME_WORDS = 153600,
    parameter int ADDR_W      = 18
) (
    input  logic              clk_ir,
    input  logic              rst_sync,
    input  logic              fb_en,
    input  logic              frame_start,
    input  logic [ADDR_W-1:0] fb_base,
    output logic              sram_rd_req,
    output logic [ADDR_W-1:0] sram_rd_addr,
    input  logic              sram_rd_gnt,
    input  logic              sram_rd_valid,
    input  logic [15:0]       sram_rd_data,
    output logic              pxl_vld,
    output logic [7:0]        pxl_data,
    input  logic              pxl_rdy,
    output logic [15:0]       underflow_cnt
);

    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_OCC_W  = c_PTR_W + 1;
    localparam int c_WCNT_W = $clog2(FRAME_WORDS + 1);
    localparam int c_PCNT_W = $clog2(2 * FRAME_WORDS + 1);

    localparam logic [c_OCC_W:0]    c_DEPTH_X   = (c_OCC_W + 1)'(FIFO_DEPTH);
    localparam logic [c_WCNT_W-1:0] c_LAST_WORD = c_WCNT_W'(FRAME_WORDS - 1);
    localparam logic [c_PCNT_W-1:0] c_PIX_TOTAL = c_PCNT_W'(2 * FRAME_WORDS);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FETCH = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    logic [1:0]          r_state;
    logic [ADDR_W-1:0]   r_base;
    logic [c_WCNT_W-1:0] r_word_cnt;
    logic [c_OCC_W-1:0]  r_inflight;
    logic [c_OCC_W-1:0]  r_drop_cnt;
    logic [15:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_OCC_W-1:0]  r_occ;
    logic                r_byte_sel;
    logic                r_pxl_vld;
    logic [7:0]          r_pxl_data;
    logic [c_PCNT_W-1:0] r_pix_cnt;
    logic [15:0]         r_underflow;

    logic                w_req;
    logic                w_gnt;
    logic                w_ret;
    logic                w_drop;
    logic                w_push;
    logic                w_hs;
    logic                w_pop;
    logic                w_starve;
    logic                w_sel_next;
    logic [c_OCC_W-1:0]  w_occ_after_pop;
    logic [c_OCC_W-1:0]  w_occ_next;
    logic [c_OCC_W-1:0]  w_inflight_next;
    logic [c_PTR_W-1:0]  w_rd_ptr_next;
    logic [15:0]         w_head_next;

    // Outstanding reads count against FIFO space so returns can always be accepted.
    assign w_req  = (r_state == c_FETCH) && fb_en &&
                    (({1'b0, r_occ} + {1'b0, r_inflight}) < c_DEPTH_X);
    assign w_gnt  = sram_rd_gnt && w_req;
    assign w_ret  = sram_rd_valid && (r_inflight != '0);
    assign w_drop = w_ret && (r_drop_cnt != '0);
    assign w_push = w_ret && !w_drop && !frame_start;
    assign w_hs   = r_pxl_vld && pxl_rdy;
    assign w_pop  = w_hs && r_byte_sel;

    assign w_occ_after_pop = r_occ - c_OCC_W'(w_pop);
    assign w_occ_next      = w_occ_after_pop + c_OCC_W'(w_push);
    assign w_inflight_next = r_inflight + c_OCC_W'(w_gnt) - c_OCC_W'(w_ret);
    assign w_rd_ptr_next   = r_rd_ptr + c_PTR_W'(w_pop);
    assign w_sel_next      = r_byte_sel ^ w_hs;
    // An empty FIFO receiving a word presents it straight away as the new head.
    assign w_head_next     = (w_occ_after_pop == '0) ? sram_rd_data : r_mem[w_rd_ptr_next];

    assign w_starve = (r_state != c_IDLE) && fb_en && pxl_rdy && !r_pxl_vld &&
                      (r_pix_cnt < c_PIX_TOTAL);

    always_ff @(posedge clk_ir) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= sram_rd_data;
        end
    end

    always_ff @(posedge clk_ir) begin
        if (rst_sync) begin
            r_state     <= c_IDLE;
            r_base      <= '0;
            r_word_cnt  <= '0;
            r_inflight  <= '0;
            r_drop_cnt  <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_occ       <= '0;
            r_byte_sel  <= 1'b0;
            r_pxl_vld   <= 1'b0;
            r_pxl_data  <= '0;
            r_pix_cnt   <= '0;
            r_underflow <= '0;
        end else begin
            r_inflight <= w_inflight_next;
            if (frame_start) begin
                r_state     <= fb_en ? c_FETCH : c_IDLE;
                r_base      <= fb_base;
                r_word_cnt  <= '0;
                // Every read still owed by SRAM belongs to the old frame.
                r_drop_cnt  <= w_inflight_next;
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_occ       <= '0;
                r_byte_sel  <= 1'b0;
                r_pxl_vld   <= 1'b0;
                r_pxl_data  <= '0;
                r_pix_cnt   <= '0;
                r_underflow <= '0;
            end else begin
                if (w_gnt) begin
                    r_word_cnt <= r_word_cnt + 1'b1;
                    if (r_word_cnt == c_LAST_WORD) begin
                        r_state <= c_DONE;
                    end
                end
                if (w_drop) begin
                    r_drop_cnt <= r_drop_cnt - 1'b1;
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                r_rd_ptr   <= w_rd_ptr_next;
                r_occ      <= w_occ_next;
                r_byte_sel <= w_sel_next;
                r_pxl_vld  <= (w_occ_next != '0);
                if (w_occ_next != '0) begin
                    r_pxl_data <= w_sel_next ? w_head_next[15:8] : w_head_next[7:0];
                end
                if (w_hs) begin
                    r_pix_cnt <= r_pix_cnt + 1'b1;
                end
                if (w_starve && (r_underflow != 16'hFFFF)) begin
                    r_underflow <= r_underflow + 1'b1;
                end
            end
        end
    end

    assign sram_rd_req   = w_req;
    assign sram_rd_addr  = r_base + ADDR_W'(r_word_cnt);
    assign pxl_vld       = r_pxl_vld;
    assign pxl_data      = r_pxl_data;
    assign underflow_cnt = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_syn_vga_fb_rdr.sv
`default_nettype none
// ============================================================================
//  Module   : tb_syn_vga_fb_rdr
//  Purpose  : Directed bench for syn_vga_fb_rdr with an in-order SRAM model
//             and address/pixel scoreboards.
//  Revision : 1.0  initial release
// ============================================================================
module tb_syn_vga_fb_rdr;

    localparam int c_FD = 16;
    localparam int c_FW = 20;
    localparam int c_AW = 18;

    logic            clk_ir = 1'b0;
    logic            rst_sync = 1'b1;
    logic            fb_en = 1'b0;
    logic            frame_start = 1'b0;
    logic [c_AW-1:0] fb_base = '0;
    logic            sram_rd_req;
    logic [c_AW-1:0] sram_rd_addr;
    logic            sram_rd_gnt = 1'b0;
    logic            sram_rd_valid = 1'b0;
    logic [15:0]     sram_rd_data = '0;
    logic            pxl_vld;
    logic [7:0]      pxl_data;
    logic            pxl_rdy = 1'b0;
    logic [15:0]     underflow_cnt;

    syn_vga_fb_rdr #(.FIFO_DEPTH(c_FD), .FRAME_WORDS(c_FW), .ADDR_W(c_AW)) dut (
        .clk_ir(clk_ir), .rst_sync(rst_sync), .fb_en(fb_en), .frame_start(frame_start),
        .fb_base(fb_base), .sram_rd_req(sram_rd_req), .sram_rd_addr(sram_rd_addr),
        .sram_rd_gnt(sram_rd_gnt), .sram_rd_valid(sram_rd_valid), .sram_rd_data(sram_rd_data),
        .pxl_vld(pxl_vld), .pxl_data(pxl_data), .pxl_rdy(pxl_rdy), .underflow_cnt(underflow_cnt)
    );

    always #5 clk_ir = ~clk_ir;

    typedef struct {
        int              due;
        logic [c_AW-1:0] addr;
    } ret_t;

    ret_t            ret_q[$];
    logic [7:0]      exp_pix_q[$];
    logic [c_AW-1:0] exp_addr_q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int lat = 2;
    int n_gnt = 0;
    bit gnt_en = 0, rdy_en = 0, fs_pend = 0, rst_v = 1, en_v = 1, last_grant = 0;
    logic [c_AW-1:0] base_v = '0;

    // SRAM content: pixel value is the low byte of (2*addr + odd).
    function automatic logic [7:0] pix(input logic [c_AW-1:0] a, input bit odd);
        logic [c_AW+1:0] t;
        t = {1'b0, a, 1'b0} + (c_AW + 2)'(odd);
        return t[7:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [c_AW-1:0] b);
        logic [c_AW-1:0] a;
        exp_pix_q.delete();
        exp_addr_q.delete();
        for (int k = 0; k < c_FW; k++) begin
            a = b + c_AW'(k);
            exp_addr_q.push_back(a);
            exp_pix_q.push_back(pix(a, 1'b0));
            exp_pix_q.push_back(pix(a, 1'b1));
        end
    endtask

    // One clock: drive inputs at the falling edge, then score what the next rising edge will take.
    task automatic step();
        logic [c_AW-1:0] ra;
        @(negedge clk_ir);
        cyc++;
        rst_sync    = rst_v;
        frame_start = fs_pend;
        fb_base     = base_v;
        fb_en       = en_v;
        sram_rd_gnt = gnt_en;
        pxl_rdy     = rdy_en;
        if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
            ra = ret_q[0].addr;
            void'(ret_q.pop_front());
            sram_rd_valid = 1'b1;
            sram_rd_data  = {pix(ra, 1'b1), pix(ra, 1'b0)};
        end else begin
            sram_rd_valid = 1'b0;
            sram_rd_data  = 16'h0000;
        end
        #1;
        last_grant = sram_rd_req && sram_rd_gnt;
        if (last_grant) begin
            n_gnt++;
            ret_q.push_back('{due: cyc + lat, addr: sram_rd_addr});
            if (!frame_start && !rst_v) begin
                chk("gnt_in_frame", 32'(exp_addr_q.size() != 0), 32'd1);
                if (exp_addr_q.size() != 0) chk("rd_addr", 32'(sram_rd_addr), 32'(exp_addr_q.pop_front()));
            end
        end
        if (pxl_vld && pxl_rdy && !frame_start && !rst_v) begin
            chk("pxl_in_frame", 32'(exp_pix_q.size() != 0), 32'd1);
            if (exp_pix_q.size() != 0) chk("pxl_data", 32'(pxl_data), 32'(exp_pix_q.pop_front()));
        end
        fs_pend = 0;
    endtask

    task automatic drain(input int limit, input string tag);
        int n;
        n = 0;
        while (exp_pix_q.size() > 0 && n < limit) begin
            step();
            n++;
        end
        chk({tag, "_drained"}, 32'(exp_pix_q.size()), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"},  32'(sram_rd_req),   32'd0);
        chk({tag, "_addr"}, 32'(sram_rd_addr),  32'd0);
        chk({tag, "_vld"},  32'(pxl_vld),       32'd0);
        chk({tag, "_data"}, 32'(pxl_data),      32'd0);
        chk({tag, "_ufl"},  32'(underflow_cnt), 32'd0);
    endtask

    initial begin
        int g0;
        int n;
        bit seen;

        // Reset
        repeat (3) step();
        rst_v = 0;
        step();
        chk_reset_outputs("reset");

        // Basic stream: hold the display off until the first pixel so no starvation is counted
        lat = 2; gnt_en = 1; rdy_en = 0; base_v = 18'h00100;
        push_frame(base_v);
        g0 = n_gnt;
        fs_pend = 1;
        step();
        chk("basic_req_on_fs_cycle", 32'(sram_rd_req), 32'd0);
        step();
        chk("basic_first_req", 32'(sram_rd_req), 32'd1);
        n = 0;
        while (!pxl_vld && n < 50) begin
            step();
            n++;
        end
        chk("basic_first_vld", 32'(pxl_vld), 32'd1);
        chk("basic_first_pix", 32'(pxl_data), 32'h00);
        rdy_en = 1;
        drain(200, "basic");
        step();
        chk("basic_grants", 32'(n_gnt - g0), 32'(c_FW));
        chk("basic_req_done", 32'(sram_rd_req), 32'd0);
        chk("basic_vld_empty", 32'(pxl_vld), 32'd0);
        chk("basic_underflow", 32'(underflow_cnt), 32'd0);

        // Backpressure: credit limit caps grants at the FIFO depth
        rdy_en = 0; base_v = 18'h01000;
        push_frame(base_v);
        fs_pend = 1;
        step();
        g0 = n_gnt;
        repeat (100) step();
        chk("bp_grants_capped", 32'(n_gnt - g0), 32'(c_FD));
        chk("bp_vld_held", 32'(pxl_vld), 32'd1);
        rdy_en = 1;
        drain(300, "bp");
        chk("bp_total_grants", 32'(n_gnt - g0), 32'(c_FW));

        // Address wrap
        lat = 3; base_v = 18'h3FFFE;
        push_frame(base_v);
        fs_pend = 1;
        step();
        drain(300, "wrap");
        chk("wrap_all_addrs", 32'(exp_addr_q.size()), 32'd0);

        // Mid-frame restart coincident with a fourth grant
        lat = 8; base_v = 18'h001C0;
        push_frame(base_v);
        fs_pend = 1;
        step();
        repeat (3) step();
        base_v = 18'h00200;
        push_frame(base_v);
        fs_pend = 1;
        step();
        chk("rs_coincident_gnt", 32'(last_grant), 32'd1);
        drain(400, "rs");
        chk("rs_all_addrs", 32'(exp_addr_q.size()), 32'd0);

        // Starvation, fb_en freeze, clear, saturation
        lat = 2; gnt_en = 0; rdy_en = 1; base_v = 18'h00300;
        push_frame(base_v);
        fs_pend = 1;
        step();
        repeat (11) step();
        chk("starve_10", 32'(underflow_cnt), 32'd10);
        en_v = 0;
        step();
        chk("en_low_req", 32'(sram_rd_req), 32'd0);
        step();
        en_v = 1;
        step();
        chk("en_high_req", 32'(sram_rd_req), 32'd1);
        chk("en_low_no_count", 32'(underflow_cnt), 32'd11);
        fs_pend = 1;
        step();
        step();
        chk("starve_clear", 32'(underflow_cnt), 32'd0);
        repeat (65540) step();
        chk("starve_saturate", 32'(underflow_cnt), 32'h0000FFFF);

        // frame_start with fb_en low returns to IDLE
        en_v = 0; fs_pend = 1;
        step();
        en_v = 1;
        step();
        repeat (3) step();
        chk("idle_req", 32'(sram_rd_req), 32'd0);
        chk("idle_ufl", 32'(underflow_cnt), 32'd0);

        // Synchronous reset mid-FETCH with reads outstanding
        lat = 6; gnt_en = 1; rdy_en = 0; base_v = 18'h00421;
        push_frame(base_v);
        fs_pend = 1;
        step();
        repeat (8) step();
        chk("pre_rst_vld", 32'(pxl_vld), 32'd1);
        chk("pre_rst_pix", 32'(pxl_data), 32'h42);
        rst_v = 1; gnt_en = 0;
        step();
        rst_v = 0;
        step();
        chk_reset_outputs("midrst");
        seen = 0;
        repeat (12) begin
            step();
            if (pxl_vld) seen = 1;
        end
        chk("rst_late_ret_no_vld", 32'(seen), 32'd0);
        chk("rst_late_ret_delivered", 32'(ret_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
